pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Return-address LIFO that pairs with the loadable program counter.
- On call: `push` captures the counter's current `cnt_out` value on `pc_in`.
- On return: `top_out` drives the counter's `cnt_in` and `pop` is asserted alongside the counter's `load`.
- Single clock domain. Sits between the PC output and the PC load mux in the VeriRISC datapath.

Parameters:
- `counter_width`, 5, bit width of stored addresses; matches the program counter width.
- `depth`, 4, number of entries; must be ≥ 2.
- `ptr_width`, 3, width of `level`; must satisfy 2^`ptr_width` > `depth`.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `push`  input  1  store `pc_in` as the new top entry.
- `pop`  input  1  discard the top entry.
- `clr_err`  input  1  synchronous clear of the sticky error flags.
- `pc_in`  input  `counter_width`  address to push (normally the PC's `cnt_out`).
- `top_out`  output  `counter_width`  current top entry (feeds the PC's `cnt_in`).
- `level`  output  `ptr_width`  number of valid entries, 0..`depth`.
- `empty`  output  1  high when `level` == 0.
- `full`  output  1  high when `level` == `depth`.
- `overflow`  output  1  sticky: a push was attempted while full.
- `underflow`  output  1  sticky: a pop was attempted while empty.

Behaviour:
- State: entry array `mem[0..depth-1]` and stack pointer `sp` (= `level`).
  - `sp` points to the next free slot; the top entry is `mem[sp-1]`.
- Reset (`rst`=1 at a rising edge):
  - `sp`=0, `overflow`=0, `underflow`=0.
  - Entries need not be cleared.
  - `rst` overrides `push`/`pop`/`clr_err` in the same cycle.
  - Reset mid-sequence discards all entries.
- Outputs after reset: `top_out`=0, `level`=0, `empty`=1, `full`=0.
- Output timing:
  - `top_out`, `level`, `empty` and `full` are combinational from registered state. There is no extra latency.
  - `top_out` = `mem[sp-1]` when `sp` > 0, else all zeros.
  - A popped value is therefore valid on `top_out` in the same cycle `pop` is asserted. The PC loads it on that edge.
- Operation on each rising edge when `rst`=0, selected by (`push`, `pop`):
  - 0,0: hold.
  - 1,0, not full: `mem[sp]` <= `pc_in`; `sp` <= `sp`+1.
  - 1,0, full: no write; `sp` unchanged; `overflow` <= 1.
  - 0,1, not empty: `sp` <= `sp`-1. The entry contents are left stale.
  - 0,1, empty: `sp` unchanged; `underflow` <= 1.
  - 1,1, not empty: replace top. `mem[sp-1]` <= `pc_in`; `sp` unchanged; no flag. This also applies when full.
  - 1,1, empty: treated as push only. `mem[0]` <= `pc_in`; `sp` <= 1; `underflow` is not set.
- Error flags:
  - `overflow` and `underflow` are sticky until `rst` or `clr_err`.
  - `clr_err` clears both flags on the edge.
  - If `clr_err` coincides with a new error event, the flag is set; set wins.
  - `clr_err` does not affect `sp` or the entries.
- No wrap-around: `sp` saturates at 0 and `depth`, and an illegal operation never corrupts existing entries.
- Entries are stored and returned unmodified; no arithmetic is applied to `pc_in`.
  - The controller decides whether to push the PC or PC+1.
- Inputs are sampled at the rising edge. Drive stimulus on the negedge and check outputs at the following negedge.

Test Plan (`counter_width`=5, `depth`=4):
- Reset: assert `rst` for 1 cycle with `push`=1, `pc_in`=5'h15 → `level`=0, `empty`=1, `top_out`=5'h00, both flags 0.
- Fill:
  - Push 5'h15, 5'h0A, 5'h1F, 5'h03 → `level` reads 1,2,3,4 in turn and `top_out` follows each pushed value.
  - After the 4th push: `full`=1.
  - A 5th push of 5'h11 → `level`=4, `top_out`=5'h03, `overflow`=1.
- Drain:
  - Pop 4 times → `top_out` reads 5'h1F, 5'h0A, 5'h15, 5'h00 after each edge; `empty`=1.
  - A 5th pop → `underflow`=1, `level`=0.
- Simultaneous push and pop:
  - With [5'h15, 5'h0A] stacked, `push`=`pop`=1, `pc_in`=5'h1C → `level`=2, `top_out`=5'h1C.
  - From empty, `push`=`pop`=1, `pc_in`=5'h07 → `level`=1, `top_out`=5'h07, `underflow`=0.
- Flag clear:
  - With both flags set, `clr_err`=1 for 1 cycle → both 0; `level` and `top_out` unchanged.
  - `clr_err`=1 together with a pop on empty → `underflow`=1.
- Reset mid-operation: after pushing 3 entries, `rst`=1 together with `pop`=1 → `level`=0, `top_out`=5'h00. A subsequent push of 5'h09 → `level`=1, `top_out`=5'h09.

Source files
------------

// File: rtl/pc_stack.sv
// Return-address LIFO for the VeriRISC program counter: push captures the PC on call,
// and top_out feeds the PC load mux on return while pop is asserted with the load.
module pc_stack #(
  parameter int counter_width = 5,
  parameter int depth         = 4,
  parameter int ptr_width     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr_err,
  input  logic [counter_width-1:0] pc_in,
  output logic [counter_width-1:0] top_out,
  output logic [ptr_width-1:0]     level,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int                   AW      = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [ptr_width-1:0] PTR_ONE = ptr_width'(1);
  localparam logic [ptr_width-1:0] PTR_MAX = ptr_width'(depth);

  logic [counter_width-1:0] mem_q [depth];
  logic [ptr_width-1:0]     sp_q, sp_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic                     ovf_evt, unf_evt;
  logic                     we;
  logic [AW-1:0]            waddr;
  logic [AW-1:0]            free_idx;
  logic [AW-1:0]            top_idx;

  assign empty     = (sp_q == '0);
  assign full      = (sp_q == PTR_MAX);
  assign level     = sp_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  // free_idx aliases when full, but it is only used for a write when not full.
  assign free_idx  = AW'(sp_q);
  assign top_idx   = AW'(sp_q - PTR_ONE);
  assign top_out   = empty ? '0 : mem_q[top_idx];

  always_comb begin
    sp_d    = sp_q;
    we      = 1'b0;
    waddr   = free_idx;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          we   = 1'b1;
          sp_d = sp_q + PTR_ONE;
        end else begin
          ovf_evt = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) sp_d = sp_q - PTR_ONE;
        else        unf_evt = 1'b1;
      end
      2'b11: begin
        // Push+pop replaces the top entry; on an empty stack it degrades to a plain push.
        we = 1'b1;
        if (!empty) begin
          waddr = top_idx;
        end else begin
          waddr = '0;
          sp_d  = PTR_ONE;
        end
      end
      default: ;
    endcase
    if (rst) we = 1'b0;
    // A new error event on the same edge as clr_err leaves the flag set.
    ovf_d = (ovf_q & ~clr_err) | ovf_evt;
    unf_d = (unf_q & ~clr_err) | unf_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= pc_in;
  end

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed scenarios followed by random traffic, both checked
// against a queue-based LIFO model with sticky error flags.
module tb_pc_stack;

  localparam int CW = 5;
  localparam int DEPTH = 4;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr_err = 1'b0;
  logic [CW-1:0] pc_in = '0;
  logic [CW-1:0] top_out;
  logic [PW-1:0] level;
  logic          empty, full, overflow, underflow;

  int checks = 0;
  int failures = 0;

  logic [CW-1:0] m_q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  pc_stack #(.counter_width(CW), .depth(DEPTH), .ptr_width(PW)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clr_err(clr_err),
    .pc_in(pc_in), .top_out(top_out), .level(level), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic p, input logic o, input logic c,
                            input logic [CW-1:0] d);
    logic oe, ue;
    oe = 1'b0;
    ue = 1'b0;
    if (r) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (p && o) begin
        if (m_q.size() > 0) m_q[m_q.size()-1] = d;
        else                m_q.push_back(d);
      end else if (p) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else                    oe = 1'b1;
      end else if (o) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
        else                ue = 1'b1;
      end
      if (c) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      m_ovf = m_ovf | oe;
      m_unf = m_unf | ue;
    end
  endtask

  task automatic check_model(input string tag);
    logic [CW-1:0] exp_top;
    exp_top = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
    check({tag, ".top"},   top_out,   exp_top);
    check({tag, ".level"}, level,     m_q.size());
    check({tag, ".empty"}, empty,     m_q.size() == 0);
    check({tag, ".full"},  full,      m_q.size() == DEPTH);
    check({tag, ".ovf"},   overflow,  m_ovf);
    check({tag, ".unf"},   underflow, m_unf);
  endtask

  // Called at a negedge: drive, let one rising edge pass, check at the next negedge.
  task automatic step(input string tag, input logic r, input logic p, input logic o,
                      input logic c, input logic [CW-1:0] d);
    rst = r; push = p; pop = o; clr_err = c; pc_in = d;
    @(posedge clk);
    model_edge(r, p, o, c, d);
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    logic [CW-1:0] fill [4];
    logic [CW-1:0] drain [4];
    fill  = '{5'h15, 5'h0A, 5'h1F, 5'h03};
    drain = '{5'h1F, 5'h0A, 5'h15, 5'h00};

    @(negedge clk);
    // Reset wins over a simultaneous push
    step("reset", 1, 1, 0, 0, 5'h15);
    check("reset.level", level, 0);
    check("reset.empty", empty, 1);
    check("reset.top", top_out, 5'h00);
    check("reset.flags", {overflow, underflow}, 2'b00);

    for (int i = 0; i < 4; i++) begin
      step("fill", 0, 1, 0, 0, fill[i]);
      check("fill.level", level, i + 1);
      check("fill.top", top_out, fill[i]);
    end
    check("fill.full", full, 1);

    step("over", 0, 1, 0, 0, 5'h11);
    check("over.level", level, 4);
    check("over.top", top_out, 5'h03);
    check("over.flag", overflow, 1);

    for (int i = 0; i < 4; i++) begin
      step("drain", 0, 0, 1, 0, 5'h00);
      check("drain.top", top_out, drain[i]);
    end
    check("drain.empty", empty, 1);

    step("under", 0, 0, 1, 0, 5'h00);
    check("under.flag", underflow, 1);
    check("under.level", level, 0);

    step("clr", 0, 0, 0, 1, 5'h00);
    check("clr.flags", {overflow, underflow}, 2'b00);
    check("clr.level", level, 0);
    check("clr.top", top_out, 5'h00);

    step("clr_set", 0, 0, 1, 1, 5'h00);
    check("clr_set.unf", underflow, 1);
    step("clr2", 0, 0, 0, 1, 5'h00);

    step("pp_a", 0, 1, 0, 0, 5'h15);
    step("pp_b", 0, 1, 0, 0, 5'h0A);
    step("pp", 0, 1, 1, 0, 5'h1C);
    check("pp.level", level, 2);
    check("pp.top", top_out, 5'h1C);

    step("pp_rst", 1, 0, 0, 0, 5'h00);
    step("pp_empty", 0, 1, 1, 0, 5'h07);
    check("pp_empty.level", level, 1);
    check("pp_empty.top", top_out, 5'h07);
    check("pp_empty.unf", underflow, 0);

    // Fill to full, then replace the top via push+pop: no overflow
    step("ppf_a", 0, 1, 0, 0, 5'h01);
    step("ppf_b", 0, 1, 0, 0, 5'h02);
    step("ppf_c", 0, 1, 0, 0, 5'h04);
    step("ppf", 0, 1, 1, 0, 5'h1E);
    check("ppf.top", top_out, 5'h1E);
    check("ppf.ovf", overflow, 0);

    step("mid_rst0", 1, 0, 0, 0, 5'h00);
    step("mid_a", 0, 1, 0, 0, 5'h12);
    step("mid_b", 0, 1, 0, 0, 5'h13);
    step("mid_c", 0, 1, 0, 0, 5'h14);
    step("mid_rst", 1, 0, 1, 0, 5'h00);
    check("mid_rst.level", level, 0);
    check("mid_rst.top", top_out, 5'h00);
    step("mid_push", 0, 1, 0, 0, 5'h09);
    check("mid_push.level", level, 1);
    check("mid_push.top", top_out, 5'h09);

    for (int n = 0; n < 400; n++) begin
      logic r, p, o, c;
      r = ($urandom_range(0, 39) == 0);
      p = ($urandom_range(0, 1) == 1);
      o = ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 7) == 0);
      step("rand", r, p, o, c, CW'($urandom));
    end

    rst = 0; push = 0; pop = 0; clr_err = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
